// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and framing-error detection
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   rx          in   serial line, asynchronous, idles high
//   data_out    out  last good byte, held until the next good frame
//   data_valid  out  one-cycle strobe, data_out updated
//   frame_error out  one-cycle strobe, stop bit sampled low
//   busy        out  high while a frame is in progress
module uart_rx #(
    parameter int CLOCK_FREQ = 1_843_200,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       busy
);
    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d, data_q, data_d;
    logic          valid_q, valid_d, ferr_q, ferr_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [1:0]    settle_q;
    logic          fall;
    // prev_q stays low until the synchronizer has flushed its preset, so a line
    // already low at reset release is not mistaken for a start edge
    assign fall = prev_q & ~sync2_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b0;
            settle_q <= 2'b00;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            sync1_q  <= rx;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q & settle_q[1];
            settle_q <= {settle_q[0], 1'b1};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = fall ? START : IDLE;
            end
            START: if (cnt_q == HALF) begin
                cnt_d   = '0;
                bit_d   = '0;
                state_d = sync2_q ? IDLE : DATA;
            end
            DATA: if (cnt_q == FULL) begin
                cnt_d   = '0;
                shift_d = {sync2_q, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                state_d = (bit_q == 3'd7) ? STOP : DATA;
            end
            STOP: if (cnt_q == FULL) begin
                cnt_d   = '0;
                state_d = IDLE;
                data_d  = sync2_q ? shift_q : data_q;
                valid_d = sync2_q;
                ferr_d  = ~sync2_q;
            end
            default: state_d = IDLE;
        endcase
    end
    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != IDLE);
endmodule
